sha256_msg_schedule: RTL and testbench

Message-schedule expander for SHA-256. It accepts one 512-bit message block and streams the 64 schedule words W[0..63] to the round/compression stage, one word per accepted beat. Expansion uses the sigma functions sha256_s0 and sha256_s1, instantiated internally, and operates on a 16-word sliding window register.

---
 rtl/sha256_msg_schedule.sv | 103 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads one 512-bit block and streams
// W[0..63] one word per accepted beat from a 16-word sliding window.

// Small sigma function: ROTR7 ^ ROTR18 ^ SHR3
module sha256_s0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

// Small sigma function: ROTR17 ^ ROTR19 ^ SHR10
module sha256_s1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_schedule #(
  parameter int OVERLAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_index,
  output logic         w_last
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        idle_rdy;
  logic        beat;
  logic        accept;
  logic [31:0] s0_out;
  logic [31:0] s1_out;
  logic [31:0] w_next;

  sha256_s0 u_s0 (.x(win[1]),  .y(s0_out));
  sha256_s1 u_s1 (.x(win[14]), .y(s1_out));

  // W[t+16] from the current window; sum wraps modulo 2^32
  assign w_next = s1_out + win[9] + s0_out + win[0];

  assign beat    = w_valid & w_ready;
  assign w_data  = win[0];
  assign w_index = t;

  // idle_rdy is registered so blk_ready stays low while rst is high; with
  // OVERLAP the last word's beat also opens the input for a seamless reload
  assign blk_ready = idle_rdy | ((OVERLAP != 0) & w_last & w_ready);
  assign accept    = blk_valid & blk_ready;

  // FSM, sliding window, round counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      w_valid  <= 1'b0;
      w_last   <= 1'b0;
      idle_rdy <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      // load has priority: in OVERLAP mode it replaces the final shift
      state    <= RUN;
      t        <= '0;
      w_valid  <= 1'b1;
      w_last   <= 1'b0;
      idle_rdy <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win[i] <= blk_data[511 - 32*i -: 32];
      end
    end else if (beat) begin
      for (int unsigned i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= w_next;
      if (t == 6'd63) begin
        state    <= IDLE;
        t        <= '0;
        w_valid  <= 1'b0;
        w_last   <= 1'b0;
        idle_rdy <= 1'b1;
      end else begin
        t      <= t + 6'd1;
        w_last <= (t == 6'd62);
      end
    end else begin
      idle_rdy <= (state == IDLE);
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: one instance per OVERLAP setting,
// expected words from an independent software expansion of each block.
module tb_sha256_msg_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         blk_valid0, blk_ready0, w_valid0, w_ready0, w_last0;
  logic [511:0] blk_data0;
  logic [31:0]  w_data0;
  logic [5:0]   w_index0;

  logic         blk_valid1, blk_ready1, w_valid1, w_ready1, w_last1;
  logic [511:0] blk_data1;
  logic [31:0]  w_data1;
  logic [5:0]   w_index1;

  sha256_msg_schedule #(.OVERLAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid0), .blk_ready(blk_ready0), .blk_data(blk_data0),
    .w_valid(w_valid0), .w_ready(w_ready0), .w_data(w_data0),
    .w_index(w_index0), .w_last(w_last0)
  );

  sha256_msg_schedule #(.OVERLAP(1)) dut1 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid1), .blk_ready(blk_ready1), .blk_data(blk_data1),
    .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1),
    .w_index(w_index1), .w_last(w_last1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [511:0] blk_abc, blk_ones, blk_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ms1(exp_w[i-2]) + exp_w[i-7] + ms0(exp_w[i-15]) + exp_w[i-16];
  endtask

  // Present a block to dut0 at a falling edge and wait for blk_ready
  task automatic accept0(input logic [511:0] blk);
    int n;
    n = 0;
    @(negedge clk);
    blk_valid0 = 1'b1;
    blk_data0  = blk;
    while (!blk_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept0_ready", 64'(blk_ready0), 64'd1);
  endtask

  // Drain 64 words from dut0 after acceptance; optional random w_ready and
  // optional persistent blk_valid carrying the next block
  task automatic stream0(input bit rnd, input bit keep, input logic [511:0] nxt);
    int idx, cyc;
    bit first, held;
    logic [31:0] hd;
    logic [5:0]  hi;
    idx = 0; cyc = 0; first = 1'b1; held = 1'b0; hd = '0; hi = '0;
    while (idx < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (keep) blk_data0 = nxt;
      else      blk_valid0 = 1'b0;
      check(first ? "latency_w_valid" : "w_valid_run", 64'(w_valid0), 64'd1);
      first = 1'b0;
      check("blk_ready_in_run", 64'(blk_ready0), 64'd0);
      if (w_valid0) begin
        if (held) begin
          check("hold_data", 64'(w_data0), 64'(hd));
          check("hold_index", 64'(w_index0), 64'(hi));
        end
        check("w_index", 64'(w_index0), 64'(idx));
        check("w_data", 64'(w_data0), 64'(exp_w[idx]));
        check("w_last", 64'(w_last0), 64'(idx == 63));
        got_w[idx] = w_data0;
      end
      w_ready0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid0 && w_ready0) begin
        idx++;
        held = 1'b0;
      end else if (w_valid0) begin
        held = 1'b1;
        hd = w_data0;
        hi = w_index0;
      end
    end
    check("beat_count", 64'(idx), 64'd64);
  endtask

  initial begin
    int idx, n;
    blk_valid0 = 1'b0; blk_data0 = '0; w_ready0 = 1'b0;
    blk_valid1 = 1'b0; blk_data1 = '0; w_ready1 = 1'b0;
    blk_abc  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    blk_ones = '1;
    for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'(32'h9E3779B9 * (i + 1));

    // reset values while rst is high
    #2;
    check("rst_w_valid", 64'(w_valid0), 64'd0);
    check("rst_w_last", 64'(w_last0), 64'd0);
    check("rst_w_index", 64'(w_index0), 64'd0);
    check("rst_w_data", 64'(w_data0), 64'd0);
    check("rst_blk_ready", 64'(blk_ready0), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_blk_ready_clocked", 64'(blk_ready0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_blk_ready", 64'(blk_ready0), 64'd1);
    check("idle_w_valid", 64'(w_valid0), 64'd0);

    // "abc" block, w_ready held high
    compute_model(blk_abc);
    accept0(blk_abc);
    stream0(1'b0, 1'b0, '0);
    check("abc_w0", 64'(got_w[0]), 64'h61626380);
    check("abc_w15", 64'(got_w[15]), 64'h00000018);
    check("abc_w16", 64'(got_w[16]), 64'h61626380);
    check("abc_w17", 64'(got_w[17]), 64'h000F0000);
    @(negedge clk);
    check("post_block_w_valid", 64'(w_valid0), 64'd0);
    check("post_block_blk_ready", 64'(blk_ready0), 64'd1);

    // same block with random backpressure
    accept0(blk_abc);
    stream0(1'b1, 1'b0, '0);

    // all-ones then blk_b back-to-back on OVERLAP=0: one idle cycle between
    compute_model(blk_ones);
    accept0(blk_ones);
    stream0(1'b0, 1'b1, blk_b);
    check("ones_w16_wrap", 64'(got_w[16]), 64'h203FFFFC);
    @(negedge clk);
    check("bubble_w_valid", 64'(w_valid0), 64'd0);
    check("bubble_blk_ready", 64'(blk_ready0), 64'd1);
    compute_model(blk_b);
    stream0(1'b0, 1'b0, '0);

    // asynchronous reset in the middle of a block
    compute_model(blk_abc);
    accept0(blk_abc);
    n = 0;
    do begin
      @(negedge clk);
      blk_valid0 = 1'b0;
      w_ready0 = 1'b1;
      n++;
    end while (w_index0 != 6'd30 && n < 100);
    check("reach_index30", 64'(w_index0), 64'd30);
    #2 rst = 1'b1;
    #1;
    check("arst_w_valid", 64'(w_valid0), 64'd0);
    check("arst_w_last", 64'(w_last0), 64'd0);
    check("arst_w_index", 64'(w_index0), 64'd0);
    check("arst_w_data", 64'(w_data0), 64'd0);
    check("arst_blk_ready", 64'(blk_ready0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_blk_ready", 64'(blk_ready0), 64'd1);
    check("arst_idle_w_valid", 64'(w_valid0), 64'd0);
    accept0(blk_abc);
    stream0(1'b0, 1'b0, '0);

    // OVERLAP=1: second block accepted in the W[63] beat with no bubble
    compute_model(blk_abc);
    @(negedge clk);
    blk_valid1 = 1'b1;
    blk_data1  = blk_abc;
    w_ready1   = 1'b1;
    check("ovl_accept_ready", 64'(blk_ready1), 64'd1);
    idx = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      blk_valid1 = 1'b0;
      if (w_valid1) begin
        check("ovl_index", 64'(w_index1), 64'(idx));
        check("ovl_data", 64'(w_data1), 64'(exp_w[idx]));
        if (idx == 63) break;
        check("ovl_ready_mid", 64'(blk_ready1), 64'd0);
        idx++;
      end
    end
    check("ovl_reach63", 64'(idx), 64'd63);
    check("ovl_last", 64'(w_last1), 64'd1);
    w_ready1   = 1'b0;
    blk_valid1 = 1'b1;
    blk_data1  = blk_ones;
    #1;
    check("ovl_ready_stalled", 64'(blk_ready1), 64'd0);
    @(negedge clk);
    check("ovl_hold63", 64'(w_index1), 64'd63);
    w_ready1 = 1'b1;
    #1;
    check("ovl_ready_last_beat", 64'(blk_ready1), 64'd1);
    @(negedge clk);
    blk_valid1 = 1'b0;
    check("ovl_nobubble_valid", 64'(w_valid1), 64'd1);
    check("ovl_nobubble_index", 64'(w_index1), 64'd0);
    check("ovl_nobubble_data", 64'(w_data1), 64'hFFFFFFFF);
    compute_model(blk_ones);
    idx = 1; n = 0;
    while (idx < 64 && n < 200) begin
      @(negedge clk);
      n++;
      if (w_valid1) begin
        check("ovl2_index", 64'(w_index1), 64'(idx));
        check("ovl2_data", 64'(w_data1), 64'(exp_w[idx]));
        check("ovl2_last", 64'(w_last1), 64'(idx == 63));
        idx++;
      end
    end
    check("ovl2_count", 64'(idx), 64'd64);
    @(negedge clk);
    check("ovl_end_w_valid", 64'(w_valid1), 64'd0);
    check("ovl_end_blk_ready", 64'(blk_ready1), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
